// File: rtl/fc_layer_seq.sv
// fc_layer_seq: sequenced fully-connected layer, one MAC per cycle over a shared memory port.
// Optional build macro FC_RELU_EN: clamp negative results to zero before writing them.
//
// Ports:
//   clk, rst_n (sync, active low), start
//   busy, done
//   mem_rd_en, mem_rd_addr, mem_rd_data (1-cycle read latency)
//   mem_wr_en, mem_wr_addr, mem_wr_data
module fc_layer_seq #(
  parameter int N_IN     = 120,
  parameter int N_OUT    = 84,
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 8,
  parameter int ADDR_W   = 14,
  parameter int IN_BASE  = 0,
  parameter int W_BASE   = 120,
  parameter int B_BASE   = 10200,
  parameter int OUT_BASE = 10284
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data
);

  localparam int ACC_W = 2*DATA_W + $clog2(N_IN) + 2;
  localparam int PW    = 2*DATA_W;
  localparam int CW    = $clog2(N_IN + 1);
  localparam int OW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic signed [ACC_W-1:0] SMAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_BIAS,
    S_MAC,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]     cnt, cnt_n;
  logic [OW-1:0]     out_cnt, out_cnt_n;
  logic [ADDR_W-1:0] w_ptr, w_ptr_n;
  logic signed [ACC_W-1:0] acc, acc_n;

  logic [ADDR_W-1:0] rd_addr_q, rd_addr_c;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_c;
  logic [DATA_W-1:0] wr_data_q, wr_data_c;

  logic signed [DATA_W-1:0] x_buf [N_IN];
  logic x_load, x_rot;

  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  shifted;
  logic        [DATA_W-1:0] sat_v;
  logic        [DATA_W-1:0] res;

  // x_buf[0] always holds the operand for the current weight.
  // Loading shifts inputs in at the top; MAC rotates the buffer
  // so it is back in order after each output node.
  assign prod = PW'($signed(mem_rd_data)) * PW'(x_buf[0]);
  assign prod_ext = ACC_W'(prod);
  assign bias_ext = ACC_W'($signed(mem_rd_data)) <<< FRAC_W;
  assign shifted  = acc >>> FRAC_W;

  always_comb begin
    sat_v = shifted[DATA_W-1:0];
    if (shifted > SMAX) begin
      sat_v = SMAX[DATA_W-1:0];
    end else if (shifted < SMIN) begin
      sat_v = SMIN[DATA_W-1:0];
    end
`ifdef FC_RELU_EN
    res = sat_v[DATA_W-1] ? '0 : sat_v;
`else
    res = sat_v;
`endif
  end

  assign x_load = (state == S_LOAD) && (cnt != '0);
  assign x_rot  = ((state == S_MAC) && (cnt != '0)) ||
                  (state == S_DRAIN);

  always_ff @(posedge clk) begin
    if (x_load || x_rot) begin
      for (int i = 0; i < N_IN-1; i++) begin
        x_buf[i] <= x_buf[i+1];
      end
      x_buf[N_IN-1] <= x_load ? $signed(mem_rd_data) : x_buf[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      out_cnt   <= '0;
      w_ptr     <= '0;
      acc       <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      out_cnt <= out_cnt_n;
      w_ptr   <= w_ptr_n;
      acc     <= acc_n;
      if (mem_rd_en) begin
        rd_addr_q <= rd_addr_c;
      end
      if (mem_wr_en) begin
        wr_addr_q <= wr_addr_c;
        wr_data_q <= wr_data_c;
      end
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    out_cnt_n = out_cnt;
    w_ptr_n   = w_ptr;
    acc_n     = acc;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    rd_addr_c = rd_addr_q;
    wr_addr_c = wr_addr_q;
    wr_data_c = wr_data_q;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n   = S_LOAD;
          cnt_n     = '0;
          out_cnt_n = '0;
          w_ptr_n   = ADDR_W'(W_BASE);
        end
      end
      S_LOAD: begin
        if (cnt != CW'(N_IN)) begin
          mem_rd_en = 1'b1;
          rd_addr_c = ADDR_W'(IN_BASE) + ADDR_W'(cnt);
          cnt_n     = cnt + 1'b1;
        end else begin
          state_n = S_BIAS;
        end
      end
      S_BIAS: begin
        mem_rd_en = 1'b1;
        rd_addr_c = ADDR_W'(B_BASE) + ADDR_W'(out_cnt);
        cnt_n     = '0;
        state_n   = S_MAC;
      end
      S_MAC: begin
        mem_rd_en = 1'b1;
        rd_addr_c = w_ptr;
        w_ptr_n   = w_ptr + 1'b1;
        // First MAC cycle sees the bias word on the read bus.
        if (cnt == '0) begin
          acc_n = bias_ext;
        end else begin
          acc_n = acc + prod_ext;
        end
        if (cnt == CW'(N_IN-1)) begin
          state_n = S_DRAIN;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        acc_n   = acc + prod_ext;
        state_n = S_WRITE;
      end
      S_WRITE: begin
        mem_wr_en = 1'b1;
        wr_addr_c = ADDR_W'(OUT_BASE) + ADDR_W'(out_cnt);
        wr_data_c = res;
        if (out_cnt == OW'(N_OUT-1)) begin
          state_n = S_DONE;
        end else begin
          out_cnt_n = out_cnt + 1'b1;
          state_n   = S_BIAS;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign mem_rd_addr = rd_addr_c;
  assign mem_wr_addr = wr_addr_c;
  assign mem_wr_data = wr_data_c;

endmodule
